// File: rtl/klein_subnibbles_serial.sv
// klein_subnibbles_serial: nibble-serial SubNibbles engine for the KLEIN round.
// NPAR shared S-boxes are applied to the low end of a 64-bit shift register.
// After 16/NPAR rotations every nibble has been substituted exactly once and
// is back in its original position. The result is then offered downstream
// over a valid/ready handshake.

// sbox: the KLEIN 4-bit S-box. It is an involution, so S(S(x)) = x.
module sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pure lookup of the 16-entry KLEIN substitution
  always_comb begin
    dout = 4'h0;
    unique case (din)
      4'h0: dout = 4'h7;
      4'h1: dout = 4'h4;
      4'h2: dout = 4'hA;
      4'h3: dout = 4'h9;
      4'h4: dout = 4'h1;
      4'h5: dout = 4'hF;
      4'h6: dout = 4'hB;
      4'h7: dout = 4'h0;
      4'h8: dout = 4'hC;
      4'h9: dout = 4'h3;
      4'hA: dout = 4'h2;
      4'hB: dout = 4'h6;
      4'hC: dout = 4'h8;
      4'hD: dout = 4'hE;
      4'hE: dout = 4'hD;
      4'hF: dout = 4'h5;
      default: dout = 4'h0;
    endcase
  end

endmodule

module klein_subnibbles_serial #(
  parameter int NPAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] state_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] state_out,
  output logic        busy
);

  localparam int STEPS = 16 / NPAR;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Only power-of-two divisors of 16 give a whole number of rotations
  generate
    if (!(NPAR == 1 || NPAR == 2 || NPAR == 4 || NPAR == 8 || NPAR == 16)) begin : g_bad_npar
      $error("klein_subnibbles_serial: NPAR must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [0:63]    sr;
  logic [0:63]    shifted;
  logic [CW-1:0]  cnt;
  logic           load;
  logic           shift;
  logic [3:0]     sub_in  [NPAR];
  logic [3:0]     sub_out [NPAR];

  // The lowest NPAR nibbles of the shift register feed the S-box bank
  generate
    for (genvar i = 0; i < NPAR; i++) begin : g_sbox
      assign sub_in[i] = sr[4*i +: 4];
      sbox u_sbox (
        .din  (sub_in[i]),
        .dout (sub_out[i])
      );
    end
  endgenerate

  // Rotate left by NPAR nibbles; substituted nibbles re-enter at the high
  // end in their original order so a full pass restores the positions
  generate
    for (genvar j = 0; j < 16; j++) begin : g_shift
      if (j < 16 - NPAR) begin : g_move
        assign shifted[4*j +: 4] = sr[4*(j+NPAR) +: 4];
      end else begin : g_fill
        assign shifted[4*j +: 4] = sub_out[j-(16-NPAR)];
      end
    end
  endgenerate

  // State register for the IDLE/RUN/HOLD controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, datapath strobes and handshake outputs, all decoded from
  // the current state so no input reaches an output except out_ready
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == LAST) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load       = 1'b1;
            next_state = RUN;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Shift register and pass counter; a load always restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= state_in;
      cnt <= '0;
    end else if (shift) begin
      sr  <= shifted;
      cnt <= cnt + CW'(1);
    end
  end

  assign state_out = sr;

endmodule

// File: tb/tb_klein_subnibbles_serial.sv
// tb_klein_subnibbles_serial: randomized and directed checks of the serial
// SubNibbles engine against a transaction-level model of the handshake.
module tb_klein_subnibbles_serial;

  localparam int LAT = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] state_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] state_out;
  logic        busy;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [0:63] state_in4, state_out4;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [0:63] state_in16, state_out16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] sb_tab [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                              4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

  // Model: results queued after a fixed latency, retired on out_ready
  int          m_left;
  bit          m_have;
  logic [63:0] m_result;
  logic [63:0] m_pending;

  klein_subnibbles_serial #(.NPAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  klein_subnibbles_serial #(.NPAR(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .state_in(state_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .state_out(state_out4), .busy(busy4)
  );

  klein_subnibbles_serial #(.NPAR(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .state_in(state_in16), .out_valid(out_valid16), .out_ready(out_ready16),
    .state_out(state_out16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sub_state(input logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = sb_tab[x[4*k +: 4]];
    return r;
  endfunction

  function automatic bit exp_in_ready();
    return (m_left == 0) && (!m_have || out_ready);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [63:0] x);
    in_valid = 1'b1;
    state_in = x;
    #1;
    check_output("accept_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output("retired", 64'(out_valid), 64'd0);
  endtask

  // Reference model advances on each clock edge, resets asynchronously
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_have   = 0;
      m_result = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_have   = 1;
        m_result = m_pending;
      end
    end else begin
      bit acc;
      acc = in_valid && (!m_have || out_ready);
      if (m_have && out_ready) m_have = 0;
      if (acc) begin
        m_pending = sub_state(state_in);
        m_left    = LAT;
      end
    end
  end

  // Every cycle, compare handshake outputs and any offered result
  always @(negedge clk) begin
    check_output("in_ready", 64'(in_ready), 64'(exp_in_ready()));
    check_output("out_valid", 64'(out_valid), 64'(m_have));
    check_output("busy", 64'(busy), 64'(m_left > 0));
    if (m_have) check_output("state_out", state_out, m_result);
  end

  initial begin
    int lat;
    logic [63:0] x;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; state_in4 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; state_in16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_state_out", state_out, 64'h0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();

    // All-zero state
    apply_stimulus(64'h0);
    wait_result(40, lat);
    check_output("zero_latency", 64'(lat), 64'd16);
    check_output("zero_value", state_out, 64'h7777777777777777);
    retire();

    // Nibble ordering
    apply_stimulus(64'h0123456789ABCDEF);
    wait_result(40, lat);
    check_output("order_latency", 64'(lat), 64'd16);
    check_output("order_value", state_out, 64'h74A91FB0C3268ED5);
    retire();

    // Back-to-back: new state loaded in the HOLD cycle
    out_ready = 1'b1;
    apply_stimulus(64'h0123456789ABCDEF);
    wait_result(40, lat);
    check_output("b2b_first", state_out, 64'h74A91FB0C3268ED5);
    in_valid = 1'b1;
    state_in = 64'h74A91FB0C3268ED5;
    #1;
    check_output("b2b_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_output("b2b_no_bubble", 64'(busy), 64'd1);
    wait_result(40, lat);
    check_output("b2b_latency", 64'(lat), 64'd16);
    check_output("b2b_value", state_out, 64'h0123456789ABCDEF);

    // Backpressure with a waiting input
    x = {$urandom, $urandom};
    in_valid = 1'b1;
    state_in = x;
    for (int c = 0; c < 10; c++) begin
      step();
      check_output("bp_in_ready", 64'(in_ready), 64'd0);
      check_output("bp_stable", state_out, 64'h0123456789ABCDEF);
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_output("bp_loaded", 64'(busy), 64'd1);
    wait_result(40, lat);
    check_output("bp_latency", 64'(lat), 64'd16);
    check_output("bp_value", state_out, sub_state(x));
    retire();

    // Asynchronous reset in the middle of a pass
    apply_stimulus({$urandom, $urandom});
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    check_output("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_output("mid_rst_state_out", state_out, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    x = {$urandom, $urandom};
    apply_stimulus(x);
    wait_result(40, lat);
    check_output("post_rst_latency", 64'(lat), 64'd16);
    check_output("post_rst_value", state_out, sub_state(x));
    retire();

    // in_valid pulses during RUN must be ignored
    x = {$urandom, $urandom};
    apply_stimulus(x);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      state_in = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    wait_result(40, lat);
    check_output("run_ignore_latency", 64'(lat), 64'd6);
    check_output("run_ignore_value", state_out, sub_state(x));
    retire();

    // Random traffic, with occasional asynchronous reset pulses
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      state_in  = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    out_ready = 1'b0;

    // Wider S-box banks shorten the latency
    in_valid4 = 1'b1;
    state_in4 = 64'h0123456789ABCDEF;
    step();
    in_valid4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid4) begin
        lat = k;
        break;
      end
    end
    check_output("npar4_latency", 64'(lat), 64'd4);
    check_output("npar4_value", state_out4, 64'h74A91FB0C3268ED5);

    in_valid16 = 1'b1;
    state_in16 = 64'h74A91FB0C3268ED5;
    step();
    in_valid16 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid16) begin
        lat = k;
        break;
      end
    end
    check_output("npar16_latency", 64'(lat), 64'd1);
    check_output("npar16_value", state_out16, 64'h0123456789ABCDEF);

    @(posedge clk);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
